accel_uart_framer: RTL and testbench

//  Downstream of the accelerometer SPI reader, upstream of the UART_TX pin.
//  - Accepts 3-axis 16-bit samples, buffers them in a small FIFO.
//  - Serialises each sample as a fixed-format byte frame on an 8N1 UART line.
//  - Counts samples dropped because the FIFO was full.

---
 rtl/accel_uart_framer_if.sv | 13 +
 rtl/accel_uart_framer.sv | 234 +++++++++++++++++++++++
 tb/tb_accel_uart_framer.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_uart_framer_if.sv
// Sample bus from the accelerometer SPI reader into the UART framer.
// No latency of its own; carries the 1-cycle s_valid strobe and three axis words.
// s_ready reports FIFO space; a strobe while s_ready is low is dropped by the slave.
interface accel_uart_framer_if;
  logic        s_valid;
  logic [15:0] s_x;
  logic [15:0] s_y;
  logic [15:0] s_z;
  logic        s_ready;

  modport master (output s_valid, s_x, s_y, s_z, input s_ready);
  modport slave  (input s_valid, s_x, s_y, s_z, output s_ready);
endinterface

// File: rtl/accel_uart_framer.sv
// Buffers 3-axis accelerometer samples and sends each one as an 8N1 UART byte frame.
// Start bit begins 2 cycles after an s_valid strobe into an empty FIFO; 70 (80 with checksum) bit-times per frame.
// No stall: s_ready=0 when the FIFO is full, and strobes then are counted in drop_count (saturating).
// Optional feature macro: ACCEL_FRAME_CHECKSUM_EN adds a trailing XOR checksum byte.
module accel_uart_framer #(
  parameter int          CLKS_PER_BIT = 106,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                 sys_clock,
  input  logic                 reset_n,
  accel_uart_framer_if.slave   s,
  output logic                 uart_tx,
  output logic                 busy,
  output logic [7:0]           drop_count,
  output logic [7:0]           frame_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CLK_W = $clog2(CLKS_PER_BIT);

`ifdef ACCEL_FRAME_CHECKSUM_EN
  localparam int NUM_BYTES = 8;
`else
  localparam int NUM_BYTES = 7;
`endif

  localparam logic [CNT_W-1:0] FULL_OCC  = CNT_W'(FIFO_DEPTH);
  localparam logic [CLK_W-1:0] CLK_LAST  = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BYTE = 3'(NUM_BYTES - 1);

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------- FIFO
  sample_t          mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occ;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  sample_t          in_sample;

  assign full      = (occ == FULL_OCC);
  assign empty     = (occ == '0);
  assign s.s_ready = ~full;
  // A strobe while full is lost even if the transmitter pops this cycle.
  assign push      = s.s_valid & ~full;
  assign in_sample = '{x: s.s_x, y: s.s_y, z: s.s_z};

  // Sample storage; no reset needed, occupancy decides what is valid.
  always_ff @(posedge sys_clock) begin
    if (push) mem[wr_ptr] <= in_sample;
  end

  // Pointers wrap naturally at the power-of-two depth; occupancy tracks push/pop.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Saturating count of samples lost to a full FIFO.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (s.s_valid && full && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  // ---------------------------------------------------------------- transmitter
  state_t           state;
  state_t           state_n;
  logic [CLK_W-1:0] clk_cnt;
  logic [CLK_W-1:0] clk_cnt_n;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_n;
  logic [2:0]       byte_idx;
  logic [2:0]       byte_idx_n;
  logic             bit_end;
  logic             frame_done;
  logic             tx_bit;
  sample_t          sample_q;
  logic [7:0]       cur_byte;

  assign bit_end = (clk_cnt == CLK_LAST);

`ifdef ACCEL_FRAME_CHECKSUM_EN
  logic [7:0] checksum;
  assign checksum = sample_q.x[7:0] ^ sample_q.x[15:8] ^
                    sample_q.y[7:0] ^ sample_q.y[15:8] ^
                    sample_q.z[7:0] ^ sample_q.z[15:8];
`endif

  // Select the byte being shifted out: sync, then each axis little-endian.
  always_comb begin
    cur_byte = 8'hFF;
    case (byte_idx)
      3'd0:    cur_byte = SYNC_BYTE;
      3'd1:    cur_byte = sample_q.x[7:0];
      3'd2:    cur_byte = sample_q.x[15:8];
      3'd3:    cur_byte = sample_q.y[7:0];
      3'd4:    cur_byte = sample_q.y[15:8];
      3'd5:    cur_byte = sample_q.z[7:0];
      3'd6:    cur_byte = sample_q.z[15:8];
`ifdef ACCEL_FRAME_CHECKSUM_EN
      3'd7:    cur_byte = checksum;
`endif
      default: cur_byte = 8'hFF;
    endcase
  end

  // Next-state, pop and line level for the start/data/stop bit sequencer.
  always_comb begin
    state_n    = state;
    clk_cnt_n  = clk_cnt;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    pop        = 1'b0;
    frame_done = 1'b0;
    tx_bit     = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_n    = START;
          clk_cnt_n  = '0;
          bit_idx_n  = '0;
          byte_idx_n = '0;
        end
      end
      START: begin
        tx_bit = 1'b0;
        if (bit_end) begin
          clk_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        tx_bit = cur_byte[bit_idx];
        if (bit_end) begin
          clk_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        tx_bit = 1'b1;
        if (bit_end) begin
          clk_cnt_n = '0;
          if (byte_idx == LAST_BYTE) begin
            state_n    = IDLE;
            frame_done = 1'b1;
          end else begin
            byte_idx_n = byte_idx + 3'd1;
            state_n    = START;
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Sequencer registers; reset mid-frame drops straight back to an idle-high line.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else begin
      state    <= state_n;
      clk_cnt  <= clk_cnt_n;
      bit_idx  <= bit_idx_n;
      byte_idx <= byte_idx_n;
    end
  end

  // Hold the popped sample for the whole frame so the FIFO slot frees immediately.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      sample_q <= '0;
    end else if (pop) begin
      sample_q <= mem[rd_ptr];
    end
  end

  // Completed-frame counter, wraps at 256.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
    end else if (frame_done) begin
      frame_count <= frame_count + 8'd1;
    end
  end

  assign uart_tx = tx_bit;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_accel_uart_framer.sv
// Randomised bench for accel_uart_framer with a queue-based reference model and line decoder.
// The model predicts pop cycles and frame bytes; the monitor decodes uart_tx and checks each bit width.
// Per-cycle checks compare s_ready, busy and drop_count against the model.
module tb_accel_uart_framer;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef ACCEL_FRAME_CHECKSUM_EN
  localparam int NB = 8;
`else
  localparam int NB = 7;
`endif
  localparam int FRAME_CYC = NB * 10 * CPB;

  logic       sys_clock = 1'b0;
  logic       reset_n   = 1'b0;
  logic       uart_tx;
  logic       busy;
  logic [7:0] drop_count;
  logic [7:0] frame_count;

  always #5 sys_clock = ~sys_clock;

  accel_uart_framer_if bus ();

  accel_uart_framer #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .sys_clock  (sys_clock),
    .reset_n    (reset_n),
    .s          (bus),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .drop_count (drop_count),
    .frame_count(frame_count)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } smp_t;

  typedef struct packed {
    logic [31:0] start;
    logic [63:0] bytes;
  } exp_t;

  smp_t mq[$];
  exp_t eq[$];
  int   cyc = 0;
  bit   m_in_frame = 0;
  int   m_fstart = 0;
  int   m_fend = 0;
  int   m_frames = 0;
  int   m_drops = 0;
  bit   m_full;
  smp_t m_s;
  exp_t m_e;

  function automatic logic [63:0] frame_bytes(input smp_t sm);
    logic [7:0] b [8];
    logic [63:0] r;
    b[0] = 8'hA5;
    b[1] = sm.x[7:0];
    b[2] = sm.x[15:8];
    b[3] = sm.y[7:0];
    b[4] = sm.y[15:8];
    b[5] = sm.z[7:0];
    b[6] = sm.z[15:8];
    b[7] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6];
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = b[i];
    return r;
  endfunction

  function automatic void model_clear();
    mq.delete();
    eq.delete();
    m_in_frame = 0;
    m_frames   = 0;
    m_drops    = 0;
  endfunction

  always @(negedge reset_n) model_clear();

  always @(posedge sys_clock) begin
    if (!reset_n) begin
      model_clear();
    end else begin
      m_full = (mq.size() == DEPTH);
      if (!m_in_frame && mq.size() > 0) begin
        m_s = mq.pop_front();
        m_e.start = 32'(cyc + 1);
        m_e.bytes = frame_bytes(m_s);
        eq.push_back(m_e);
        m_in_frame = 1;
        m_fstart   = cyc + 1;
        m_fend     = cyc + FRAME_CYC;
      end else if (m_in_frame && cyc == m_fend) begin
        m_in_frame = 0;
        m_frames++;
      end
      if (bus.s_valid) begin
        if (m_full) m_drops = (m_drops == 255) ? 255 : m_drops + 1;
        else        mq.push_back('{x: bus.s_x, y: bus.s_y, z: bus.s_z});
      end
    end
    cyc++;
  end

  // Cycle-by-cycle status comparison against the model.
  always @(negedge sys_clock) begin
    if (reset_n) begin
      check("s_ready", bus.s_ready, mq.size() < DEPTH);
      check("drop_count", drop_count, m_drops);
      check("busy", busy, m_in_frame && (cyc >= m_fstart));
    end
  end

  // ---------------------------------------------------------------- line monitor
  logic [7:0] last_frame [8];
  int         mon_last_len = 0;

  task automatic read_bit(input bit have_first, output logic val, output bit bad, output bit abort);
    bad   = 0;
    abort = 0;
    val   = 1'b0;
    if (!have_first) begin
      @(negedge sys_clock);
      if (!reset_n) begin abort = 1; return; end
      val = uart_tx;
    end
    for (int i = 1; i < CPB; i++) begin
      @(negedge sys_clock);
      if (!reset_n) begin abort = 1; return; end
      if (uart_tx !== val) bad = 1;
    end
  endtask

  task automatic decode_frame();
    exp_t       e;
    bit         have_exp;
    logic       v;
    bit         bad;
    bit         ab;
    bit         err;
    logic [7:0] byt;
    int         start_cyc;
    start_cyc = cyc;
    have_exp  = 0;
    e         = '0;
    if (eq.size() == 0) begin
      check("unexpected frame", 1, 0);
    end else begin
      e = eq.pop_front();
      have_exp = 1;
      check("frame start cycle", start_cyc, e.start);
    end
    for (int b = 0; b < NB; b++) begin
      err = 0;
      read_bit(b == 0, v, bad, ab);
      if (ab) return;
      err |= bad | (v !== 1'b0);
      for (int i = 0; i < 8; i++) begin
        read_bit(0, v, bad, ab);
        if (ab) return;
        byt[i] = v;
        err |= bad;
      end
      read_bit(0, v, bad, ab);
      if (ab) return;
      err |= bad | (v !== 1'b1);
      last_frame[b] = byt;
      check($sformatf("bit framing byte%0d", b), err, 0);
      if (have_exp) check($sformatf("frame byte%0d", b), byt, e.bytes[8*b +: 8]);
    end
    mon_last_len = cyc - start_cyc + 1;
    @(negedge sys_clock);
    if (!reset_n) return;
    check("frame_count after frame", frame_count, 8'(m_frames));
    check("idle gap high", uart_tx, 1'b1);
  endtask

  initial begin : monitor
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge sys_clock);
      if (!reset_n) begin
        prev = 1'b1;
      end else if (prev === 1'b1 && uart_tx === 1'b0) begin
        decode_frame();
        prev = reset_n ? uart_tx : 1'b1;
      end else begin
        prev = uart_tx;
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic drive(input smp_t sm);
    bus.s_valid = 1'b1;
    bus.s_x     = sm.x;
    bus.s_y     = sm.y;
    bus.s_z     = sm.z;
  endtask

  function automatic smp_t rnd_smp();
    smp_t r;
    r.x = 16'($urandom);
    r.y = 16'($urandom);
    r.z = 16'($urandom);
    return r;
  endfunction

  task automatic send(input smp_t sm);
    @(negedge sys_clock);
    drive(sm);
    @(negedge sys_clock);
    bus.s_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((m_in_frame || mq.size() > 0) && n < budget) begin
      @(negedge sys_clock);
      n++;
    end
    check("drain within budget", n < budget, 1'b1);
    repeat (4) @(negedge sys_clock);
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] t2 [8];
    logic [7:0] t6 [8];
    int n;
    t2 = '{8'hA5, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h0F, 8'h0F, 8'h40};
    t6 = '{8'hA5, 8'h00, 8'h80, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h80};
    bus.s_valid = 1'b0;
    bus.s_x = '0;
    bus.s_y = '0;
    bus.s_z = '0;
    reset_n = 1'b0;

    // Reset state
    #300;
    check("reset uart_tx", uart_tx, 1'b1);
    check("reset s_ready", bus.s_ready, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset drop_count", drop_count, 8'd0);
    check("reset frame_count", frame_count, 8'd0);
    @(negedge sys_clock);
    reset_n = 1'b1;
    repeat (3) @(negedge sys_clock);

    // Single known frame
    send('{x: 16'h1234, y: 16'hABCD, z: 16'h0F0F});
    drain(FRAME_CYC + 50);
    for (int b = 0; b < NB; b++) check($sformatf("t2 byte%0d", b), last_frame[b], t2[b]);
    check("t2 frame length", mon_last_len, FRAME_CYC);
    check("t2 frame_count", frame_count, 8'd1);
    check("t2 busy after", busy, 1'b0);

    // Six strobes back to back into an empty FIFO
    @(negedge sys_clock);
    for (int i = 0; i < 6; i++) begin
      drive(rnd_smp());
      if (i == 5) check("t3 s_ready low on 6th strobe", bus.s_ready, 1'b0);
      @(negedge sys_clock);
    end
    bus.s_valid = 1'b0;
    drain(6 * FRAME_CYC);
    check("t3 drop_count", drop_count, 8'd1);
    check("t3 frame_count", frame_count, 8'd6);

    // Drop counter saturation
    @(negedge sys_clock);
    for (int i = 0; i < 305; i++) begin
      drive(rnd_smp());
      @(negedge sys_clock);
    end
    bus.s_valid = 1'b0;
    check("t4 drop_count saturated", drop_count, 8'hFF);
    drain(6 * FRAME_CYC);
    check("t4 drop_count held", drop_count, 8'hFF);
    check("t4 frame_count", frame_count, 8'd11);

    // Reset in the middle of byte 3
    @(negedge sys_clock);
    for (int i = 0; i < 3; i++) begin
      drive(rnd_smp());
      @(negedge sys_clock);
    end
    bus.s_valid = 1'b0;
    n = 0;
    while (!busy && n < 50) begin
      @(negedge sys_clock);
      n++;
    end
    check("t5 busy seen", busy, 1'b1);
    repeat (34 * CPB) @(posedge sys_clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5 uart_tx on reset", uart_tx, 1'b1);
    check("t5 busy on reset", busy, 1'b0);
    check("t5 s_ready on reset", bus.s_ready, 1'b1);
    check("t5 frame_count on reset", frame_count, 8'd0);
    repeat (3) @(negedge sys_clock);
    reset_n = 1'b1;
    repeat (20) @(negedge sys_clock);
    check("t5 line idle after reset", uart_tx, 1'b1);
    check("t5 fifo empty after reset", busy, 1'b0);
    send(rnd_smp());
    drain(FRAME_CYC + 50);
    check("t5 clean frame sync", last_frame[0], 8'hA5);
    check("t5 frame_count", frame_count, 8'd1);

    // Sign-boundary sample
    send('{x: 16'h8000, y: 16'hFFFF, z: 16'h0000});
    drain(FRAME_CYC + 50);
    for (int b = 0; b < NB; b++) check($sformatf("t6 byte%0d", b), last_frame[b], t6[b]);

    // Random traffic with random gaps
    for (int i = 0; i < 25; i++) begin
      send(rnd_smp());
      repeat ($urandom_range(0, FRAME_CYC / 2)) @(negedge sys_clock);
    end
    drain(6 * FRAME_CYC);
    check("pending expected frames", eq.size(), 0);
    check("final frame_count", frame_count, 8'(m_frames));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
